// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set controller for the 24-hour BCD counter (edit hours/minutes, blink, commit load)
module clock_set_ctrl #(
    parameter int BLINK_DIV   = 500,
    parameter int TIMEOUT     = 10000,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] cur_time,
    output logic        run_en,
    output logic        load_en,
    output logic [23:0] load_time,
    output logic [5:0]  blink_mask,
    output logic [1:0]  set_mode
);
    localparam logic [1:0] S_RUN = 2'd0, S_HR = 2'd1, S_MIN = 2'd2, S_COMMIT = 2'd3;
    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [1:0]    r_state;
    logic          r_prev_mode, r_prev_inc, r_prev_dec;
    logic [7:0]    r_hr, r_min;
    logic [23:0]   r_load_time;
    logic [RW-1:0] r_rpt;
    logic [TW-1:0] r_idle;
    logic [BW-1:0] r_bdiv;
    logic          r_phase;

    logic       w_mode_p, w_inc_p, w_dec_p, w_hold_inc, w_hold_dec, w_tick;
    logic       w_inc_ev, w_dec_ev, w_up, w_dn, w_busy, w_timeout, w_hr_ok, w_min_ok;
    logic [1:0] w_next;
    logic       w_unused;

    // BCD +/-1 with wrap between 00 and max, digit by digit
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up, input logic [7:0] max);
        if (up)
            return (v == max) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
        return (v == 8'h00) ? max : (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
    endfunction

    assign w_unused   = ^cur_time[7:0];
    assign w_mode_p   = btn_mode & ~r_prev_mode;
    assign w_inc_p    = btn_inc & ~r_prev_inc;
    assign w_dec_p    = btn_dec & ~r_prev_dec;
    assign w_hold_inc = btn_inc & ~btn_dec;
    assign w_hold_dec = btn_dec & ~btn_inc;
    assign w_tick     = (w_hold_inc | w_hold_dec) && r_rpt == RW'(REPEAT_DLY);
    assign w_inc_ev   = w_inc_p | (w_tick & w_hold_inc);
    assign w_dec_ev   = w_dec_p | (w_tick & w_hold_dec);
    assign w_up       = w_inc_ev & ~w_dec_ev & ~w_mode_p;
    assign w_dn       = w_dec_ev & ~w_inc_ev & ~w_mode_p;
    assign w_busy     = btn_mode | btn_inc | btn_dec;
    assign w_timeout  = !w_busy && r_idle == TW'(TIMEOUT - 1);
    assign w_hr_ok    = cur_time[23:20] <= 4'd2 && cur_time[19:16] <= 4'd9 && cur_time[23:16] <= 8'h23;
    assign w_min_ok   = cur_time[15:12] <= 4'd5 && cur_time[11:8] <= 4'd9;
    assign w_next     = (r_state == S_COMMIT) ? S_RUN :
                        (r_state == S_RUN)    ? (w_mode_p ? S_HR : S_RUN) :
                        w_mode_p              ? ((r_state == S_HR) ? S_MIN : S_COMMIT) :
                        w_timeout             ? S_RUN : r_state;

    always_ff @(posedge kh_clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_prev_mode <= 1'b1;
            r_prev_inc  <= 1'b1;
            r_prev_dec  <= 1'b1;
            r_hr        <= 8'h00;
            r_min       <= 8'h00;
            r_load_time <= 24'h0;
            r_rpt       <= '0;
            r_idle      <= '0;
            r_bdiv      <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_prev_mode <= btn_mode;
            r_prev_inc  <= btn_inc;
            r_prev_dec  <= btn_dec;
            r_rpt       <= !(w_hold_inc | w_hold_dec) ? '0 :
                           w_tick ? RW'(REPEAT_DLY - REPEAT_RATE + 1) : r_rpt + 1'b1;
            r_idle      <= (r_state == S_RUN || r_state == S_COMMIT || w_busy || w_next != r_state)
                           ? '0 : r_idle + 1'b1;
            if (r_state == S_RUN && w_mode_p) begin
                r_hr  <= w_hr_ok ? cur_time[23:16] : 8'h00;
                r_min <= w_min_ok ? cur_time[15:8] : 8'h00;
            end else if (r_state == S_HR && (w_up | w_dn))
                r_hr  <= bcd_step(r_hr, w_up, 8'h23);
            else if (r_state == S_MIN && (w_up | w_dn))
                r_min <= bcd_step(r_min, w_up, 8'h59);
            if (r_state == S_MIN && w_mode_p)
                r_load_time <= {r_hr, r_min, 8'h00};
            if (w_next != r_state) begin
                r_bdiv  <= '0;
                r_phase <= 1'b0;
            end else if (r_bdiv == BW'(BLINK_DIV - 1)) begin
                r_bdiv  <= '0;
                r_phase <= ~r_phase;
            end else
                r_bdiv  <= r_bdiv + 1'b1;
        end
    end

    assign run_en     = r_state == S_RUN;
    assign load_en    = r_state == S_COMMIT;
    assign load_time  = r_load_time;
    assign set_mode   = r_state;
    assign blink_mask = !r_phase ? 6'b000000 : (r_state == S_HR) ? 6'b110000 :
                        (r_state == S_MIN) ? 6'b001100 : 6'b000000;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed checks of the time-set controller with short timing parameters
module tb_clock_set_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [23:0] cur_time = 24'h123456;
    logic        run_en, load_en;
    logic [23:0] load_time;
    logic [5:0]  blink_mask;
    logic [1:0]  set_mode;
    int          checks = 0, errors = 0, load_cnt = 0, lc0;

    clock_set_ctrl #(.BLINK_DIV(4), .TIMEOUT(20), .REPEAT_DLY(6), .REPEAT_RATE(2)) dut (
        .kh_clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_time(cur_time), .run_en(run_en), .load_en(load_en), .load_time(load_time),
        .blink_mask(blink_mask), .set_mode(set_mode)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (load_en) load_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_mode;
        btn_mode = 1'b1; tick(1); btn_mode = 1'b0; tick(1);
    endtask
    task automatic pulse_inc;
        btn_inc = 1'b1; tick(1); btn_inc = 1'b0; tick(1);
    endtask
    task automatic pulse_dec;
        btn_dec = 1'b1; tick(1); btn_dec = 1'b0; tick(1);
    endtask

    // mode press from SET_MIN: one COMMIT cycle then back to RUN
    task automatic commit(input string tag, input logic [23:0] exp);
        btn_mode = 1'b1; tick(1);
        chk({tag, "_load_en"}, {23'd0, load_en}, 24'd1);
        chk({tag, "_mode3"}, {22'd0, set_mode}, 24'd3);
        chk({tag, "_time"}, load_time, exp);
        btn_mode = 1'b0; tick(1);
        chk({tag, "_load_off"}, {23'd0, load_en}, 24'd0);
        chk({tag, "_run"}, {22'd0, set_mode, run_en}, 24'b001);
        chk({tag, "_hold"}, load_time, exp);
    endtask

    initial begin
        tick(3);
        chk("rst_run_en", {23'd0, run_en}, 24'd1);
        chk("rst_mode", {22'd0, set_mode}, 24'd0);
        chk("rst_blink", {18'd0, blink_mask}, 24'd0);
        chk("rst_load", {23'd0, load_en}, 24'd0);
        chk("rst_ltime", load_time, 24'h0);
        reset = 1'b0; tick(1);

        btn_mode = 1'b1; tick(1);
        chk("enter_hr", {22'd0, set_mode, run_en}, 24'b010);
        btn_mode = 1'b0; tick(1);
        pulse_inc; pulse_inc;
        pulse_mode;
        chk("enter_min", {22'd0, set_mode}, 24'd2);
        pulse_dec;
        lc0 = load_cnt;
        commit("set", 24'h143300);
        chk("set_pulses", 24'(load_cnt - lc0), 24'd1);

        cur_time = 24'h235912;
        pulse_mode; pulse_inc; pulse_mode; pulse_inc;
        commit("wrap_up", 24'h000000);
        cur_time = 24'h001500;
        pulse_mode; pulse_dec; pulse_mode;
        commit("wrap_dn", 24'h231500);

        cur_time = 24'h050000;
        pulse_mode;
        btn_inc = 1'b1; tick(13); btn_inc = 1'b0; tick(1);
        pulse_mode;
        commit("repeat", 24'h100000);

        lc0 = load_cnt;
        pulse_mode; pulse_mode;
        tick(18);
        chk("to_before", {22'd0, set_mode}, 24'd2);
        tick(1);
        chk("to_after", {22'd0, set_mode, run_en}, 24'b001);
        chk("to_noload", 24'(load_cnt - lc0), 24'd0);
        chk("to_ltime", load_time, 24'h100000);

        cur_time = 24'h083000;
        pulse_mode;
        tick(2);
        chk("blink_0a", {18'd0, blink_mask}, 24'h0);
        tick(1);
        chk("blink_1a", {18'd0, blink_mask}, 24'b110000);
        tick(3);
        chk("blink_1b", {18'd0, blink_mask}, 24'b110000);
        tick(1);
        chk("blink_0b", {18'd0, blink_mask}, 24'h0);
        btn_inc = 1'b1; btn_dec = 1'b1; tick(1); btn_inc = 1'b0; btn_dec = 1'b0; tick(1);
        btn_mode = 1'b1; btn_inc = 1'b1; tick(1);
        chk("mode_inc", {22'd0, set_mode}, 24'd2);
        chk("min_blink", {18'd0, blink_mask}, 24'h0);
        btn_mode = 1'b0; btn_inc = 1'b0; tick(1);
        commit("collide", 24'h083000);

        cur_time = 24'h2A7B00;
        pulse_mode; pulse_mode;
        commit("invalid", 24'h000000);

        cur_time = 24'h123456;
        pulse_mode; pulse_inc;
        lc0 = load_cnt;
        reset = 1'b1; tick(1);
        chk("midrst_mode", {22'd0, set_mode, run_en}, 24'b001);
        chk("midrst_ltime", load_time, 24'h0);
        reset = 1'b0; tick(2);
        chk("midrst_noload", 24'(load_cnt - lc0), 24'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
